// File: rtl/clock_gate_ctrl.sv
// Clock-gate controller: stops the gated domain clock after a programmable idle
// period and restarts it on demand, holding off clk_ready until the clock settles.
module clock_gate_ctrl #(
  parameter int IDLE_W = 8,
  parameter int WAKE_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              busy,
  input  logic              te,
  input  logic              cfg_disable,
  input  logic [IDLE_W-1:0] cfg_idle_thresh,
  input  logic [WAKE_W-1:0] cfg_wake_lat,
  output logic              gate_en,
  output logic              clk_ready,
  output logic              gated,
  output logic [CNT_W-1:0]  gate_count
);

  typedef enum logic [1:0] {RUN, COUNT, GATED, WAKE} state_t;

  state_t            state;
  logic [IDLE_W-1:0] idle_cnt;
  logic [WAKE_W-1:0] wake_cnt;
  logic              en_q;
  logic              wake_cond;

  assign wake_cond = req_valid | busy | cfg_disable;

  // Test enable bypasses the FSM so scan always sees a running clock.
  assign gate_en = en_q | te;

  // NOTE: every state and output register here updates with <= so all of them
  // see the same pre-edge values; blocking assignments would create ordering races.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= RUN;
      idle_cnt   <= '0;
      wake_cnt   <= '0;
      gate_count <= '0;
      en_q       <= 1'b1;
      clk_ready  <= 1'b1;
      gated      <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (!wake_cond && cfg_idle_thresh != '0) begin
            state    <= COUNT;
            idle_cnt <= IDLE_W'(1);
          end else begin
            idle_cnt <= '0;
          end
        end

        COUNT: begin
          if (wake_cond || cfg_idle_thresh == '0) begin
            state    <= RUN;
            idle_cnt <= '0;
          end else if (idle_cnt >= cfg_idle_thresh) begin
            // >= so a threshold lowered mid-count gates immediately.
            state     <= GATED;
            idle_cnt  <= '0;
            en_q      <= 1'b0;
            clk_ready <= 1'b0;
            gated     <= 1'b1;
            if (gate_count != '1) gate_count <= gate_count + CNT_W'(1);
          end else begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
          end
        end

        GATED: begin
          if (wake_cond) begin
            state    <= WAKE;
            wake_cnt <= '0;
            en_q     <= 1'b1;
            gated    <= 1'b0;
          end
        end

        WAKE: begin
          // Once started, a wake always completes so the clock settles fully.
          if (wake_cnt >= cfg_wake_lat) begin
            state     <= RUN;
            wake_cnt  <= '0;
            clk_ready <= 1'b1;
          end else begin
            wake_cnt <= wake_cnt + WAKE_W'(1);
          end
        end

        default: begin
          state     <= RUN;
          idle_cnt  <= '0;
          wake_cnt  <= '0;
          en_q      <= 1'b1;
          clk_ready <= 1'b1;
          gated     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// Directed bench for clock_gate_ctrl with a reduced gate_count width so the
// saturation point is reachable in a few gate/wake rounds.
module tb_clock_gate_ctrl;

  localparam int IDLE_W = 8;
  localparam int WAKE_W = 4;
  localparam int CNT_W  = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              busy;
  logic              te;
  logic              cfg_disable;
  logic [IDLE_W-1:0] cfg_idle_thresh;
  logic [WAKE_W-1:0] cfg_wake_lat;
  logic              gate_en;
  logic              clk_ready;
  logic              gated;
  logic [CNT_W-1:0]  gate_count;

  int n_tests = 0;
  int n_fail  = 0;

  clock_gate_ctrl #(.IDLE_W(IDLE_W), .WAKE_W(WAKE_W), .CNT_W(CNT_W)) dut (
    .clock          (clock),
    .reset          (reset),
    .req_valid      (req_valid),
    .busy           (busy),
    .te             (te),
    .cfg_disable    (cfg_disable),
    .cfg_idle_thresh(cfg_idle_thresh),
    .cfg_wake_lat   (cfg_wake_lat),
    .gate_en        (gate_en),
    .clk_ready      (clk_ready),
    .gated          (gated),
    .gate_count     (gate_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit before sampling.
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic en, input logic rdy, input logic gt);
    check({tag, ".gate_en"},   32'(gate_en),   32'(en));
    check({tag, ".clk_ready"}, 32'(clk_ready), 32'(rdy));
    check({tag, ".gated"},     32'(gated),     32'(gt));
  endtask

  // From GATED with cfg_wake_lat = 0: one-cycle request, back to RUN two edges later.
  task automatic wake_fast(input string tag);
    req_valid = 1'b1;
    step(1);
    check_outs({tag, ".wake"}, 1'b1, 1'b0, 1'b0);
    req_valid = 1'b0;
    step(1);
    check_outs({tag, ".run"}, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; busy = 1'b0; te = 1'b0; cfg_disable = 1'b0;
    cfg_idle_thresh = 8'd4; cfg_wake_lat = 4'd0;

    // Reset state.
    step(2);
    check_outs("reset", 1'b1, 1'b1, 1'b0);
    check("reset.count", 32'(gate_count), 32'd0);

    // thresh=4, idle from the first edge: still enabled after 4 edges, gated after 5.
    reset = 1'b0;
    step(4);
    check_outs("gate4.pre", 1'b1, 1'b1, 1'b0);
    step(1);
    check_outs("gate4.post", 1'b0, 1'b0, 1'b1);
    check("gate4.count", 32'(gate_count), 32'd1);

    // Wake with latency 3 from a single-cycle request that drops during WAKE.
    cfg_wake_lat = 4'd3;
    req_valid = 1'b1;
    step(1);
    check_outs("wake3.w1", 1'b1, 1'b0, 1'b0);
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("wake3.not_ready", 32'(clk_ready), 32'd0);
    end
    step(1);
    check_outs("wake3.ready", 1'b1, 1'b1, 1'b0);

    // Busy on the 3rd idle cycle restarts the idle count; clock never drops early.
    step(2);
    busy = 1'b1;
    step(1);
    check_outs("busy.run", 1'b1, 1'b1, 1'b0);
    busy = 1'b0;
    step(4);
    check_outs("busy.restart", 1'b1, 1'b1, 1'b0);
    step(1);
    check_outs("busy.gated", 1'b0, 1'b0, 1'b1);
    check("busy.count", 32'(gate_count), 32'd2);

    // Test enable forces gate_en without disturbing the FSM.
    te = 1'b1;
    #1;
    check_outs("te.on", 1'b1, 1'b0, 1'b1);
    step(1);
    check_outs("te.hold", 1'b1, 1'b0, 1'b1);
    te = 1'b0;
    #1;
    check_outs("te.off", 1'b0, 1'b0, 1'b1);

    // Saturation of the 2-bit gate counter: 3 then stays 3.
    cfg_wake_lat = 4'd0;
    wake_fast("sat1");
    step(5);
    check("sat1.gated", 32'(gated), 32'd1);
    check("sat1.count", 32'(gate_count), 32'd3);
    wake_fast("sat2");
    step(5);
    check("sat2.gated", 32'(gated), 32'd1);
    check("sat2.count", 32'(gate_count), 32'd3);

    // Threshold set to 0 mid-count abandons the count and disables gating.
    wake_fast("thr0");
    cfg_idle_thresh = 8'd8;
    step(3);
    cfg_idle_thresh = 8'd0;
    step(1);
    check_outs("thr0.run", 1'b1, 1'b1, 1'b0);
    step(12);
    check_outs("thr0.hold", 1'b1, 1'b1, 1'b0);

    // Threshold lowered below the running idle count gates on the next edge.
    cfg_idle_thresh = 8'd8;
    step(5);
    check_outs("lower.pre", 1'b1, 1'b1, 1'b0);
    cfg_idle_thresh = 8'd2;
    step(1);
    check_outs("lower.gated", 1'b0, 1'b0, 1'b1);

    // Minimum threshold of 1: gated two edges after idle begins in RUN.
    wake_fast("thr1");
    cfg_idle_thresh = 8'd1;
    step(1);
    check_outs("thr1.count", 1'b1, 1'b1, 1'b0);
    step(1);
    check_outs("thr1.gated", 1'b0, 1'b0, 1'b1);

    // cfg_disable wakes from GATED, then holds the clock on indefinitely.
    cfg_wake_lat = 4'd3;
    cfg_disable  = 1'b1;
    step(1);
    check_outs("dis.wake", 1'b1, 1'b0, 1'b0);
    step(4);
    check_outs("dis.run", 1'b1, 1'b1, 1'b0);
    step(20);
    check_outs("dis.hold", 1'b1, 1'b1, 1'b0);

    // Reset asserted during WAKE returns to RUN on the next edge.
    cfg_disable = 1'b0;
    step(2);
    check_outs("rst.gated", 1'b0, 1'b0, 1'b1);
    cfg_disable = 1'b1;
    step(1);
    check_outs("rst.wake", 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    step(1);
    check_outs("rst.run", 1'b1, 1'b1, 1'b0);
    check("rst.count", 32'(gate_count), 32'd0);
    reset = 1'b0;
    step(10);
    check_outs("rst.hold", 1'b1, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
